// File: rtl/led_scan_sequencer_pkg.sv
// Shared constants, types and the per-tick position rule for the LED scan sequencer.
package led_scan_pkg;

  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  typedef struct packed {
    logic [2:0] sel;
    dir_t       dir;
    logic       wrap;
  } pos_t;

  // Position, direction and wrap flag that one tick produces in the given mode.
  function automatic pos_t advance(input logic [1:0] mode, input logic [2:0] sel,
                                   input dir_t dir);
    pos_t r;
    r.sel  = sel;
    r.dir  = dir;
    r.wrap = 1'b0;
    case (mode)
      MODE_UP: begin
        r.sel  = sel + 3'd1;
        r.dir  = DIR_UP;
        r.wrap = (sel == 3'd7);
      end
      MODE_DOWN: begin
        r.sel  = sel - 3'd1;
        r.dir  = DIR_DOWN;
        r.wrap = (sel == 3'd0);
      end
      MODE_BOUNCE: begin
        // Reversal steps straight to the neighbour instead of dwelling on the end.
        if (dir == DIR_UP) begin
          if (sel == 3'd7) begin
            r.sel  = 3'd6;
            r.dir  = DIR_DOWN;
            r.wrap = 1'b1;
          end else begin
            r.sel = sel + 3'd1;
          end
        end else begin
          if (sel == 3'd0) begin
            r.sel  = 3'd1;
            r.dir  = DIR_UP;
            r.wrap = 1'b1;
          end else begin
            r.sel = sel - 3'd1;
          end
        end
      end
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/led_scan_sequencer_if.sv
// Control and decoder-side signals of the LED scan sequencer.
interface led_scan_sequencer_if;
  logic       run;
  logic [1:0] mode;
  logic       disp_en;
  logic       load;
  logic [2:0] load_val;
  logic [2:0] sel;
  logic       sel_en;
  logic       step;
  logic       wrap;

  modport master (
    output run, mode, disp_en, load, load_val,
    input  sel, sel_en, step, wrap
  );

  modport slave (
    input  run, mode, disp_en, load, load_val,
    output sel, sel_en, step, wrap
  );
endinterface

// File: rtl/led_scan_sequencer_tick_gen.sv
// Prescaler: one tick every PRESCALE cycles in which run is high; clr restarts the count.
module tick_gen #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  assign tick = run && (cnt_reg == LAST);

  // The count is held, not cleared, while run is low.
  always_comb begin
    cnt_next = cnt_reg;
    if (clr || tick) begin
      cnt_next = '0;
    end else if (run) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/led_scan_sequencer.sv
// 3-bit scan position generator for a 3-to-8 decoder: up, down, bounce and hold modes.
module led_scan_sequencer #(
  parameter int PRESCALE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  led_scan_sequencer_if.slave  bus
);
  import led_scan_pkg::*;

  logic       tick;
  logic [2:0] sel_reg;
  logic [2:0] sel_next;
  dir_t       dir_reg;
  dir_t       dir_next;
  logic       step_reg;
  logic       step_next;
  logic       wrap_reg;
  logic       wrap_next;
  logic       sel_en_reg;
  pos_t       adv;

  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .run  (bus.run),
    .clr  (bus.load),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_reg    <= 3'd0;
      dir_reg    <= DIR_UP;
      step_reg   <= 1'b0;
      wrap_reg   <= 1'b0;
      sel_en_reg <= 1'b0;
    end else begin
      sel_reg    <= sel_next;
      dir_reg    <= dir_next;
      step_reg   <= step_next;
      wrap_reg   <= wrap_next;
      sel_en_reg <= bus.disp_en;
    end
  end

  // A load wins over a coincident tick and swallows its step pulse.
  always_comb begin
    adv       = advance(bus.mode, sel_reg, dir_reg);
    sel_next  = sel_reg;
    dir_next  = dir_reg;
    step_next = 1'b0;
    wrap_next = 1'b0;
    if (bus.load) begin
      sel_next = bus.load_val;
      dir_next = DIR_UP;
    end else if (tick) begin
      sel_next  = adv.sel;
      dir_next  = adv.dir;
      step_next = 1'b1;
      wrap_next = adv.wrap;
    end
  end

  always_comb begin
    bus.sel    = sel_reg;
    bus.sel_en = sel_en_reg;
    bus.step   = step_reg;
    bus.wrap   = wrap_reg;
  end

endmodule

// File: tb/tb_led_scan_sequencer.sv
// Drives a PRESCALE=4 and a PRESCALE=1 sequencer with identical stimulus and scores both
// against a position/direction reference model.
module tb_led_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [1:0] mode;
  logic       disp_en;
  logic       load;
  logic [2:0] load_val;

  always #5 clk = ~clk;

  led_scan_sequencer_if if4 ();
  led_scan_sequencer_if if1 ();

  assign if4.run = run;      assign if1.run = run;
  assign if4.mode = mode;    assign if1.mode = mode;
  assign if4.disp_en = disp_en;  assign if1.disp_en = disp_en;
  assign if4.load = load;    assign if1.load = load;
  assign if4.load_val = load_val;  assign if1.load_val = load_val;

  led_scan_sequencer #(.PRESCALE(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  led_scan_sequencer #(.PRESCALE(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  typedef struct packed {
    logic [2:0] sel;
    logic       sel_en;
    logic       step;
    logic       wrap;
  } obs_t;

  typedef struct packed {
    obs_t p4;
    obs_t p1;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model state: position 0..7, direction +1/-1, run-cycles since last step/load/reset.
  int pos[2];
  int dir[2];
  int runs[2];
  int presc[2] = '{4, 1};

  task automatic compare(input string name, input int act, input int exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
    end
  endtask

  // Apply the current inputs for one rising edge and queue what both DUTs must show after it.
  task automatic cycle();
    obs_t o[2];
    exp_t e;
    int   nxt;
    for (int k = 0; k < 2; k++) begin
      o[k].step = 1'b0;
      o[k].wrap = 1'b0;
      if (rst) begin
        pos[k] = 0; dir[k] = 1; runs[k] = 0;
      end else if (load) begin
        pos[k] = int'(load_val); dir[k] = 1; runs[k] = 0;
      end else if (run) begin
        runs[k]++;
        if (runs[k] == presc[k]) begin
          runs[k] = 0;
          o[k].step = 1'b1;
          case (mode)
            2'b00: begin
              o[k].wrap = (pos[k] == 7);
              pos[k] = (pos[k] + 1) % 8;
              dir[k] = 1;
            end
            2'b01: begin
              o[k].wrap = (pos[k] == 0);
              pos[k] = (pos[k] + 7) % 8;
              dir[k] = -1;
            end
            2'b10: begin
              nxt = pos[k] + dir[k];
              if (nxt < 0 || nxt > 7) begin
                dir[k] = -dir[k];
                nxt = pos[k] + dir[k];
                o[k].wrap = 1'b1;
              end
              pos[k] = nxt;
            end
            default: ;
          endcase
        end
      end
      o[k].sel    = 3'(pos[k]);
      o[k].sel_en = rst ? 1'b0 : disp_en;
    end
    e.p4 = o[0];
    e.p1 = o[1];
    @(posedge clk);
    q.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      compare("p4.sel",    int'(if4.sel),    int'(e.p4.sel));
      compare("p4.sel_en", int'(if4.sel_en), int'(e.p4.sel_en));
      compare("p4.step",   int'(if4.step),   int'(e.p4.step));
      compare("p4.wrap",   int'(if4.wrap),   int'(e.p4.wrap));
      compare("p1.sel",    int'(if1.sel),    int'(e.p1.sel));
      compare("p1.sel_en", int'(if1.sel_en), int'(e.p1.sel_en));
      compare("p1.step",   int'(if1.step),   int'(e.p1.step));
      compare("p1.wrap",   int'(if1.wrap),   int'(e.p1.wrap));
    end
  end

  initial begin
    rst = 1'b1; run = 1'b1; mode = 2'b00; disp_en = 1'b1; load = 1'b0; load_val = 3'd0;
    for (int k = 0; k < 2; k++) begin
      pos[k] = 0; dir[k] = 1; runs[k] = 0;
    end
    repeat (3) cycle();
    rst = 1'b0;
    repeat (40) cycle();

    // Bounce through both reversals.
    load = 1'b1; load_val = 3'd0; cycle(); load = 1'b0;
    mode = 2'b10;
    repeat (70) cycle();

    // Loads at every prescaler phase, including coincident with a tick.
    mode = 2'b00;
    for (int ph = 0; ph < 4; ph++) begin
      repeat (ph) cycle();
      load = 1'b1; load_val = 3'(5 + ph); cycle(); load = 1'b0;
      repeat (6) cycle();
    end

    // Freeze mid-count.
    load = 1'b1; load_val = 3'd2; cycle(); load = 1'b0;
    repeat (2) cycle();
    run = 1'b0;
    repeat (10) cycle();
    run = 1'b1;
    repeat (6) cycle();

    // Reset during a downward bounce sweep.
    load = 1'b1; load_val = 3'd6; cycle(); load = 1'b0;
    mode = 2'b10;
    repeat (14) cycle();
    rst = 1'b1; cycle(); rst = 1'b0;
    repeat (9) cycle();

    // Down-wrap, then hold, then enable toggling.
    mode = 2'b01;
    repeat (20) cycle();
    mode = 2'b11;
    repeat (10) cycle();
    disp_en = 1'b0; cycle(); disp_en = 1'b1; cycle();

    for (int i = 0; i < 3000; i++) begin
      run = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) disp_en = ~disp_en;
      load = ($urandom_range(0, 39) == 0);
      load_val = 3'($urandom_range(0, 7));
      rst = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst = 1'b0; load = 1'b0;

    repeat (3) @(negedge clk);
    compare("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
